// File: rtl/arp_recv_gmii.sv
// ---------------------------------------------------------------------------
// arp_recv_gmii
// Receive-side ARP parser on a byte-wide GMII stream (125 MHz, clk domain).
// Checks the Ethernet header (destination = LOCAL_MAC or broadcast, ethertype
// 0x0806), the fixed ARP body fields, the target IP and the frame length.
// Each accepted request/reply produces a one-cycle arp_valid strobe together
// with the sender MAC/IP.
//
// Optional feature: define ARP_RX_CRC_CHECK_EN to add an FCS (CRC-32) check.
// A frame that is otherwise valid but whose FCS is wrong then pulses crc_err
// instead of arp_valid. Without the macro there is no CRC logic and crc_err
// is tied low.
//
// Ports
//   clk           in   125 MHz receive byte clock
//   rst           in   synchronous active-high reset
//   gmii_rx_data  in   received byte
//   gmii_rx_dv    in   byte valid, frame active while high
//   gmii_rx_er    in   PHY receive error
//   arp_valid     out  one-cycle strobe, frame accepted
//   arp_is_reply  out  1 = oper 0x0002, 0 = oper 0x0001
//   arp_src_mac   out  ARP sender hardware address
//   arp_src_ip    out  ARP sender protocol address
//   crc_err       out  one-cycle strobe on FCS failure (0 without the macro)
// ---------------------------------------------------------------------------
module arp_recv_gmii #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_00_02,
    parameter int unsigned MAX_LEN   = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rx_data,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        arp_valid,
    output logic        arp_is_reply,
    output logic [47:0] arp_src_mac,
    output logic [31:0] arp_src_ip,
    output logic        crc_err
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, BODY, TAIL, DROP} state_t;

    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_C = 11'd64;

    state_t      state_q;
    logic        armed_q;        // dv has been seen low since reset / last frame
    logic [2:0]  pre_q;          // number of 0x55 preamble bytes seen
    logic [10:0] cnt_q;          // bytes after SFD, saturating
    logic        bc_q, lo_q;     // destination MAC still matches broadcast / local
    logic        reply_sh_q;
    logic [47:0] mac_sh_q;
    logic [31:0] ip_sh_q;
    logic        arp_valid_q, arp_is_reply_q;
    logic [47:0] arp_src_mac_q;
    logic [31:0] arp_src_ip_q;

    // Expected value of the fixed bytes of header and ARP body, by position.
    logic [7:0] exp_byte, mac_byte;
    logic       exp_chk;
    always_comb begin
        exp_byte = 8'h00;
        exp_chk  = 1'b0;
        mac_byte = 8'h00;
        case (cnt_q)
            11'd0:  mac_byte = LOCAL_MAC[47:40];
            11'd1:  mac_byte = LOCAL_MAC[39:32];
            11'd2:  mac_byte = LOCAL_MAC[31:24];
            11'd3:  mac_byte = LOCAL_MAC[23:16];
            11'd4:  mac_byte = LOCAL_MAC[15:8];
            11'd5:  mac_byte = LOCAL_MAC[7:0];
            11'd12: begin exp_byte = 8'h08; exp_chk = 1'b1; end
            11'd13: begin exp_byte = 8'h06; exp_chk = 1'b1; end
            11'd14: begin exp_byte = 8'h00; exp_chk = 1'b1; end
            11'd15: begin exp_byte = 8'h01; exp_chk = 1'b1; end
            11'd16: begin exp_byte = 8'h08; exp_chk = 1'b1; end
            11'd17: begin exp_byte = 8'h00; exp_chk = 1'b1; end
            11'd18: begin exp_byte = 8'h06; exp_chk = 1'b1; end
            11'd19: begin exp_byte = 8'h04; exp_chk = 1'b1; end
            11'd20: begin exp_byte = 8'h00; exp_chk = 1'b1; end
            11'd38: begin exp_byte = LOCAL_IP[31:24]; exp_chk = 1'b1; end
            11'd39: begin exp_byte = LOCAL_IP[23:16]; exp_chk = 1'b1; end
            11'd40: begin exp_byte = LOCAL_IP[15:8];  exp_chk = 1'b1; end
            11'd41: begin exp_byte = LOCAL_IP[7:0];   exp_chk = 1'b1; end
            default: ;
        endcase
    end

    // Destination MAC match is tracked in parallel for broadcast and local;
    // the frame is dropped as soon as neither candidate still matches.
    logic dest_bc, dest_lo, byte_ok;
    logic [10:0] cnt_inc;
    assign dest_bc = (cnt_q == 11'd0 || bc_q) && (gmii_rx_data == 8'hFF);
    assign dest_lo = (cnt_q == 11'd0 || lo_q) && (gmii_rx_data == mac_byte);
    assign byte_ok = (!exp_chk || gmii_rx_data == exp_byte)
                  && (cnt_q > 11'd5 || dest_bc || dest_lo)
                  && (cnt_q != 11'd21 || gmii_rx_data == 8'h01 || gmii_rx_data == 8'h02);
    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

    logic len_ok;
    assign len_ok = (cnt_q >= MIN_LEN_C) && (cnt_q <= MAX_LEN_C);

`ifdef ARP_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;
    logic        crc_err_q;
    // Reflected CRC-32, one byte per clock, no final inversion: running it
    // across data plus FCS leaves the fixed residue on a good frame.
    always_comb begin
        crc_d = crc_q ^ {24'h0, gmii_rx_data};
        for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB88320) : (crc_d >> 1);
        end
    end
    logic crc_ok;
    assign crc_ok  = (crc_q == 32'hDEBB20E3);
    assign crc_err = crc_err_q;
`else
    logic crc_ok;
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            armed_q        <= 1'b0;
            pre_q          <= 3'd0;
            cnt_q          <= 11'd0;
            bc_q           <= 1'b0;
            lo_q           <= 1'b0;
            reply_sh_q     <= 1'b0;
            mac_sh_q       <= 48'h0;
            ip_sh_q        <= 32'h0;
            arp_valid_q    <= 1'b0;
            arp_is_reply_q <= 1'b0;
            arp_src_mac_q  <= 48'h0;
            arp_src_ip_q   <= 32'h0;
`ifdef ARP_RX_CRC_CHECK_EN
            crc_q          <= 32'hFFFFFFFF;
            crc_err_q      <= 1'b0;
`endif
        end else begin
            arp_valid_q <= 1'b0;
`ifdef ARP_RX_CRC_CHECK_EN
            crc_err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!gmii_rx_dv) begin
                        armed_q <= 1'b1;
                    end else if (armed_q && gmii_rx_data == 8'h55) begin
                        state_q <= PREAMBLE;
                        pre_q   <= 3'd1;
                    end else begin
                        // Joined mid-frame: wait for the gap before listening.
                        armed_q <= 1'b0;
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                        armed_q <= 1'b1;
                    end else if (gmii_rx_er) begin
                        state_q <= DROP;
                    end else if (gmii_rx_data == 8'h55) begin
                        if (pre_q == 3'd7) state_q <= DROP;
                        else               pre_q   <= pre_q + 3'd1;
                    end else if (gmii_rx_data == 8'hD5) begin
                        state_q <= HEADER;
                        cnt_q   <= 11'd0;
`ifdef ARP_RX_CRC_CHECK_EN
                        crc_q   <= 32'hFFFFFFFF;
`endif
                    end else begin
                        state_q <= DROP;
                    end
                end
                HEADER, BODY: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                        armed_q <= 1'b1;
                    end else if (gmii_rx_er || !byte_ok) begin
                        state_q <= DROP;
                    end else begin
                        cnt_q <= cnt_inc;
`ifdef ARP_RX_CRC_CHECK_EN
                        crc_q <= crc_d;
`endif
                        if (cnt_q <= 11'd5) begin
                            bc_q <= dest_bc;
                            lo_q <= dest_lo;
                        end
                        if (cnt_q == 11'd21) reply_sh_q <= gmii_rx_data[1];
                        if (cnt_q >= 11'd22 && cnt_q <= 11'd27)
                            mac_sh_q <= {mac_sh_q[39:0], gmii_rx_data};
                        if (cnt_q >= 11'd28 && cnt_q <= 11'd31)
                            ip_sh_q <= {ip_sh_q[23:0], gmii_rx_data};
                        if (cnt_q == 11'd13) state_q <= BODY;
                        if (cnt_q == 11'd41) state_q <= TAIL;
                    end
                end
                TAIL: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                        armed_q <= 1'b1;
                        if (len_ok) begin
                            if (crc_ok) begin
                                arp_valid_q    <= 1'b1;
                                arp_is_reply_q <= reply_sh_q;
                                arp_src_mac_q  <= mac_sh_q;
                                arp_src_ip_q   <= ip_sh_q;
                            end else begin
`ifdef ARP_RX_CRC_CHECK_EN
                                crc_err_q <= 1'b1;
`endif
                            end
                        end
                    end else if (gmii_rx_er) begin
                        state_q <= DROP;
                    end else begin
                        cnt_q <= cnt_inc;
`ifdef ARP_RX_CRC_CHECK_EN
                        crc_q <= crc_d;
`endif
                    end
                end
                DROP: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                        armed_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arp_valid    = arp_valid_q;
    assign arp_is_reply = arp_is_reply_q;
    assign arp_src_mac  = arp_src_mac_q;
    assign arp_src_ip   = arp_src_ip_q;

endmodule

// File: tb/tb_arp_recv_gmii.sv
module tb_arp_recv_gmii;

    localparam logic [47:0] LOCAL_MAC = 48'h000A3501FEC0;
    localparam logic [47:0] BCAST     = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SMAC      = 48'h000A3501FEC1;
    localparam logic [31:0] MY_IP     = 32'hC0A80002;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gmii_rx_data;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        arp_valid;
    logic        arp_is_reply;
    logic [47:0] arp_src_mac;
    logic [31:0] arp_src_ip;
    logic        crc_err;

    int checks   = 0;
    int failures = 0;
    int vpulse   = 0;
    int cpulse   = 0;

    arp_recv_gmii dut (
        .clk          (clk),
        .rst          (rst),
        .gmii_rx_data (gmii_rx_data),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .arp_valid    (arp_valid),
        .arp_is_reply (arp_is_reply),
        .arp_src_mac  (arp_src_mac),
        .arp_src_ip   (arp_src_ip),
        .crc_err      (crc_err)
    );

    always #4 clk = ~clk;

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (arp_valid === 1'b1) vpulse++;
        if (crc_err === 1'b1)   cpulse++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er, input logic r);
        @(negedge clk);
        gmii_rx_data = d;
        gmii_rx_dv   = dv;
        gmii_rx_er   = er;
        rst          = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // 64-byte ARP frame (42 bytes + 18 pad + FCS), sent after 7x55 + D5.
    // trunc: number of post-SFD bytes sent; er_at/rst_at: byte index or -1.
    task automatic send_frame(input logic [47:0] dmac, input logic [15:0] etype,
                              input logic [15:0] oper, input logic [31:0] sip,
                              input logic [31:0] tip, input int trunc,
                              input int er_at, input int rst_at, input bit bad_fcs);
        logic [7:0]  f [64];
        logic [31:0] c;
        for (int i = 0; i < 64; i++) f[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            f[i]      = dmac[8*(5-i) +: 8];
            f[6 + i]  = SMAC[8*(5-i) +: 8];
            f[22 + i] = SMAC[8*(5-i) +: 8];
        end
        f[12] = etype[15:8]; f[13] = etype[7:0];
        f[14] = 8'h00; f[15] = 8'h01; f[16] = 8'h08; f[17] = 8'h00;
        f[18] = 8'h06; f[19] = 8'h04; f[20] = oper[15:8]; f[21] = oper[7:0];
        for (int i = 0; i < 4; i++) begin
            f[28 + i] = sip[8*(3-i) +: 8];
            f[38 + i] = tip[8*(3-i) +: 8];
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) c = crc_byte(c, f[i]);
        c = ~c;
        f[60] = c[7:0]; f[61] = c[15:8]; f[62] = c[23:16]; f[63] = c[31:24];
        if (bad_fcs) f[63] = f[63] ^ 8'h01;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0, 1'b0);
        drive(8'hD5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < trunc; i++)
            drive(f[i], 1'b1, (i == er_at), (i == rst_at));
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int v0, c0;
        rst = 1'b1; gmii_rx_data = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("rst_valid", arp_valid, 0);
        check("rst_reply", arp_is_reply, 0);
        check("rst_mac",   arp_src_mac, 0);
        check("rst_ip",    arp_src_ip, 0);
        check("rst_crc",   crc_err, 0);

        // 1: broadcast request, strobe exactly one cycle after dv falls
        v0 = vpulse;
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80003, MY_IP, 64, -1, -1, 0);
        @(negedge clk);
        check("f1_valid", arp_valid, 1);
        check("f1_reply", arp_is_reply, 0);
        check("f1_mac",   arp_src_mac, 48'h000A3501FEC1);
        check("f1_ip",    arp_src_ip, 32'hC0A80003);
        @(negedge clk);
        check("f1_width", arp_valid, 0);
        check("f1_pulses", vpulse - v0, 1);
        $display("frame 1 broadcast request: pulses=%0d ip=%h", vpulse - v0, arp_src_ip);
        idle(10);

        // 2: wrong target IP
        v0 = vpulse;
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80063, 32'hC0A80009, 64, -1, -1, 0);
        idle(12);
        check("f2_pulses", vpulse - v0, 0);
        check("f2_ip_hold", arp_src_ip, 32'hC0A80003);
        $display("frame 2 wrong target ip: pulses=%0d", vpulse - v0);

        // 3: wrong ethertype
        v0 = vpulse;
        send_frame(BCAST, 16'h0800, 16'h0001, 32'hC0A80064, MY_IP, 64, -1, -1, 0);
        idle(12);
        check("f3_pulses", vpulse - v0, 0);
        check("f3_ip_hold", arp_src_ip, 32'hC0A80003);
        $display("frame 3 wrong ethertype: pulses=%0d", vpulse - v0);

        // 4: corrupted FCS
        v0 = vpulse; c0 = cpulse;
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80003, MY_IP, 64, -1, -1, 1);
        @(negedge clk);
`ifdef ARP_RX_CRC_CHECK_EN
        check("f4_crc_err", crc_err, 1);
        idle(11);
        check("f4_valid_pulses", vpulse - v0, 0);
        check("f4_crc_pulses", cpulse - c0, 1);
`else
        check("f4_valid", arp_valid, 1);
        idle(11);
        check("f4_valid_pulses", vpulse - v0, 1);
        check("f4_crc_pulses", cpulse - c0, 0);
`endif
        $display("frame 4 bad fcs: valid=%0d crc_err=%0d", vpulse - v0, cpulse - c0);

        // 5: rx_er at byte 20; 6: truncated to 50 bytes
        v0 = vpulse; c0 = cpulse;
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80065, MY_IP, 64, 20, -1, 0);
        idle(12);
        check("f5_pulses", (vpulse - v0) + (cpulse - c0), 0);
        $display("frame 5 rx_er: strobes=%0d", (vpulse - v0) + (cpulse - c0));
        v0 = vpulse; c0 = cpulse;
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80066, MY_IP, 50, -1, -1, 0);
        idle(12);
        check("f6_pulses", (vpulse - v0) + (cpulse - c0), 0);
        check("f6_ip_hold", arp_src_ip, 32'hC0A80003);
        $display("frame 6 truncated: strobes=%0d", (vpulse - v0) + (cpulse - c0));

        // 7: good unicast request after the bad ones
        v0 = vpulse;
        send_frame(LOCAL_MAC, 16'h0806, 16'h0001, 32'hC0A80004, MY_IP, 64, -1, -1, 0);
        @(negedge clk);
        check("f7_valid", arp_valid, 1);
        check("f7_ip", arp_src_ip, 32'hC0A80004);
        idle(11);
        check("f7_pulses", vpulse - v0, 1);
        $display("frame 7 unicast request: pulses=%0d ip=%h", vpulse - v0, arp_src_ip);

        // 8: reset mid-frame at byte 30 of a reply
        v0 = vpulse;
        send_frame(LOCAL_MAC, 16'h0806, 16'h0002, 32'hC0A80008, MY_IP, 64, -1, 30, 0);
        idle(12);
        check("f8_pulses", vpulse - v0, 0);
        check("f8_mac_clr", arp_src_mac, 0);
        check("f8_ip_clr", arp_src_ip, 0);
        $display("frame 8 reset mid-frame: pulses=%0d ip=%h", vpulse - v0, arp_src_ip);

        // 9: good reply
        v0 = vpulse;
        send_frame(LOCAL_MAC, 16'h0806, 16'h0002, 32'hC0A80007, MY_IP, 64, -1, -1, 0);
        @(negedge clk);
        check("f9_valid", arp_valid, 1);
        check("f9_reply", arp_is_reply, 1);
        check("f9_ip", arp_src_ip, 32'hC0A80007);
        idle(11);
        check("f9_pulses", vpulse - v0, 1);
        $display("frame 9 reply: pulses=%0d reply=%0d", vpulse - v0, arp_is_reply);

        // 10/11: two requests separated by the minimum gap
        v0 = vpulse;
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80005, MY_IP, 64, -1, -1, 0);
        @(negedge clk);
        check("f10_ip", arp_src_ip, 32'hC0A80005);
        idle(11);
        send_frame(BCAST, 16'h0806, 16'h0001, 32'hC0A80006, MY_IP, 64, -1, -1, 0);
        @(negedge clk);
        check("f11_ip", arp_src_ip, 32'hC0A80006);
        check("f11_reply", arp_is_reply, 0);
        idle(4);
        check("f10_11_pulses", vpulse - v0, 2);
        $display("frames 10-11 back to back: pulses=%0d ip=%h", vpulse - v0, arp_src_ip);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
